conv_enc_213: RTL and testbench
===============================

Name: conv_enc_213

Overview:
- Frame-based (2,1,3) convolutional encoder; the transmit-side counterpart of the bVITERBI_213 decoder.
- Accepts one information bit per handshake and emits one 2-bit code symbol per bit.
- After each frame it appends M zero tail bits, returning the trellis to state 0. The decoder's traceback therefore starts from a known state.
- Sits between the data source and the channel model/decoder Rx input in system benches.

Parameters:
- N, 2, code symbol width (bits out per info bit).
- K, 1, info bits in per step.
- M, 3, encoder memory (8 trellis states).
- G0, 4'b1111, generator for Tx[1]; MSB taps the current input bit.
- G1, 4'b1101, generator for Tx[0]; MSB taps the current input bit.
- FRAME_LEN, 12, info bits per frame, range 1..255.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a frame; honoured only in IDLE.
- Dx  in  K  information bit.
- din_valid  in  1  Dx is valid.
- din_ready  out  1  encoder accepts Dx this cycle.
- Tx  out  N  code symbol.
- oe  out  1  Tx is valid.
- tx_ready  in  1  downstream consumes Tx this cycle.
- tx_last  out  1  qualifies the final tail symbol of the frame; valid while oe=1.
- busy  out  1  high whenever state is not IDLE.
- err_mask  in  N  error-injection mask; used only with ERR_INJECT_EN.

Behaviour:
- Reset (asynchronous, reset=0): state=IDLE; shift register s[M-1:0]=0; bit count=0; Tx=0; oe=0; tx_last=0; busy=0; din_ready=0.
- Encoding:
  - Window w = {u, s[0], s[1], s[2]}, where s[0] is the most recent bit.
  - Tx[1] = ^(w & G0); Tx[0] = ^(w & G1).
  - After each step: s <= {s[1:0], u}.
- Output stage: a single register.
  - slot_free = !oe || tx_ready.
  - When a symbol is produced, Tx and oe are loaded at the same edge; one-cycle latency from input acceptance.
  - When oe && tx_ready and no new symbol is produced, oe clears.
- State machine:
  - IDLE: on start → DATA; s cleared; count cleared. start outside IDLE is ignored.
  - DATA:
    - din_ready = slot_free.
    - din_valid && din_ready: encode u=Dx, count++.
    - When the FRAME_LEN-th bit is accepted → TAIL, count=0.
  - TAIL:
    - din_ready=0.
    - When slot_free: encode u=0 internally, count++.
    - The M-th tail symbol is loaded with tx_last=1; → DRAIN.
  - DRAIN: when oe && tx_ready on the tx_last symbol → IDLE, with s == 0.
- Back-to-back frames: a start pulse in the same cycle DRAIN exits is ignored. A new frame requires start while in IDLE.
- Throughput: one symbol per cycle with tx_ready held high. tx_ready=0 stalls everything without loss, and Tx/oe/tx_last hold steady.
- Total symbols per frame: FRAME_LEN+M.
- Reset asserted mid-frame: the partial frame is discarded and outputs immediately return to reset values.

Optional Feature:
- Macro ERR_INJECT_EN.
- Defined: Tx is loaded as the encoded symbol XOR err_mask, sampled at the load edge. Tail symbols are masked too. This lets benches exercise decoder error correction.
- Undefined: err_mask is ignored (port kept, unconnected internally) and Tx is always the clean code.

Decomposition:
- Shared package conv213_pkg holds:
  - N, K, M, G0, G1;
  - state enum {IDLE, DATA, TAIL, DRAIN};
  - a parity function that returns the N-bit symbol for a given u and s.
- The decoder's branch-metric logic reuses the same package, so generators are defined once.
- No sub-module is needed; the parity function covers the combinational part.

Test Plan:
- FRAME_LEN=4, tx_ready=1, Dx=1,0,1,1 → Tx sequence 11,11,01,11,01,01,11; tx_last only on the 7th symbol; busy falls after it; final s=000.
- All-zero frame (FRAME_LEN=12) → 15 symbols of 00; tx_last on the 15th.
- Frame of 1,0,1,1 with tx_ready toggling 1,0 each cycle → same 7 symbols; Tx/oe stable while tx_ready=0; din_ready low while oe && !tx_ready.
- start pulsed during DATA, and again in the same cycle DRAIN exits → ignored in both cases; only a later start in IDLE begins a new frame.
- reset asserted after the 2nd data bit → oe=0, busy=0, Tx=00 asynchronously. A new frame then encodes from s=000, matching the first scenario.
- With ERR_INJECT_EN defined and err_mask=10 on the 3rd symbol of the first scenario → 11,11,11,11,01,01,11. Feeding this to bVITERBI_213 recovers 1,0,1,1.

Source files
------------

// File: rtl/conv213_pkg.sv
// Shared definitions for the (2,1,3) convolutional code.
// Encoder and decoder both import this package so the generators live in one place.
package conv213_pkg;

  localparam int N = 2;
  localparam int K = 1;
  localparam int M = 3;

  // MSB of each generator taps the current input bit, lower bits tap older bits
  localparam logic [M:0] G0 = 4'b1111;
  localparam logic [M:0] G1 = 4'b1101;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    TAIL,
    DRAIN
  } state_t;

  // Code symbol for input bit u and shift register s (s[0] is the most recent bit)
  function automatic logic [N-1:0] parity(input logic u, input logic [M-1:0] s);
    logic [M:0] w;
    w[M] = u;
    for (int i = 0; i < M; i++) begin
      w[M-1-i] = s[i];
    end
    return {^(w & G0), ^(w & G1)};
  endfunction

endpackage

// File: rtl/conv_enc_213.sv
// Frame-based (2,1,3) convolutional encoder with zero-tail termination.
// Each frame carries FRAME_LEN info bits followed by M zero tail bits so the
// trellis always ends in state 0.
// Optional build macro ERR_INJECT_EN: XORs err_mask into every loaded symbol.
module conv_enc_213
  import conv213_pkg::*;
#(
  parameter int FRAME_LEN = 12
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [K-1:0] Dx,
  input  logic         din_valid,
  output logic         din_ready,
  output logic [N-1:0] Tx,
  output logic         oe,
  input  logic         tx_ready,
  output logic         tx_last,
  output logic         busy,
  input  logic [N-1:0] err_mask
);

  state_t       state;
  state_t       next_state;
  logic [M-1:0] s_reg;
  logic [7:0]   count;
  logic         slot_free;
  logic         produce;
  logic         last_sym;
  logic         u;
  logic [N-1:0] sym_out;

  assign slot_free = !oe || tx_ready;
  assign busy      = (state != IDLE);

`ifdef ERR_INJECT_EN
  assign sym_out = parity(u, s_reg) ^ err_mask;
`else
  logic unused_err_mask;
  assign unused_err_mask = ^err_mask;
  assign sym_out = parity(u, s_reg);
`endif

  // Next-state decode plus the per-cycle "produce a symbol" decision
  always_comb begin
    next_state = state;
    produce    = 1'b0;
    last_sym   = 1'b0;
    u          = 1'b0;
    din_ready  = 1'b0;
    case (state)
      IDLE: begin
        if (start) next_state = DATA;
      end
      DATA: begin
        din_ready = slot_free;
        if (din_valid && slot_free) begin
          produce = 1'b1;
          u       = Dx[0];
          if (count == 8'(FRAME_LEN - 1)) next_state = TAIL;
        end
      end
      TAIL: begin
        if (slot_free) begin
          produce = 1'b1;
          if (count == 8'(M - 1)) begin
            last_sym   = 1'b1;
            next_state = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (oe && tx_ready && tx_last) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // State register, shift register and per-phase bit counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      s_reg <= '0;
      count <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && start) begin
        s_reg <= '0;
        count <= '0;
      end else if (produce) begin
        s_reg <= {s_reg[M-2:0], u};
        count <= (next_state != state) ? 8'd0 : count + 8'd1;
      end
    end
  end

  // Single-entry output register; holds while downstream stalls
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      Tx      <= '0;
      oe      <= 1'b0;
      tx_last <= 1'b0;
    end else if (produce) begin
      Tx      <= sym_out;
      oe      <= 1'b1;
      tx_last <= last_sym;
    end else if (oe && tx_ready) begin
      oe      <= 1'b0;
      tx_last <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_enc_213.sv
// Self-checking bench for conv_enc_213: directed frames plus randomized
// frames and backpressure, checked against a convolution-sum reference model.
module tb_conv_enc_213;

  localparam int FL = 4;
  localparam int MEM = 3;
  localparam logic [3:0] GEN0 = 4'b1111;
  localparam logic [3:0] GEN1 = 4'b1101;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [0:0] Dx;
  logic       din_valid;
  logic       din_ready;
  logic [1:0] Tx;
  logic       oe;
  logic       tx_ready;
  logic       tx_last;
  logic       busy;
  logic [1:0] err_mask;

  int n_checks = 0;
  int n_fail   = 0;

  int         frame_bits[$];
  logic [1:0] exp_syms[$];
  logic [1:0] obs_syms[$];
  logic [1:0] golden[7] = '{2'b11, 2'b11, 2'b01, 2'b11, 2'b01, 2'b01, 2'b11};

  always #5 clock = ~clock;

  conv_enc_213 #(.FRAME_LEN(FL)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .Dx       (Dx),
    .din_valid(din_valid),
    .din_ready(din_ready),
    .Tx       (Tx),
    .oe       (oe),
    .tx_ready (tx_ready),
    .tx_last  (tx_last),
    .busy     (busy),
    .err_mask (err_mask)
  );

  // Count one comparison and report it if it does not match
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Reference: each symbol is a mod-2 convolution of the zero-padded bit stream with the generators
  function automatic void buildExpected();
    int total;
    total = frame_bits.size() + MEM;
    exp_syms.delete();
    for (int k = 0; k < total; k++) begin
      int a;
      int b;
      a = 0;
      b = 0;
      for (int j = 0; j <= MEM; j++) begin
        int idx;
        int bv;
        idx = k - j;
        bv  = (idx >= 0 && idx < frame_bits.size()) ? frame_bits[idx] : 0;
        a   = a ^ (bv & int'(GEN0[MEM-j]));
        b   = b ^ (bv & int'(GEN1[MEM-j]));
      end
      exp_syms.push_back({a[0], b[0]});
    end
  endfunction

  function automatic logic [1:0] pickMask();
`ifdef ERR_INJECT_EN
    return 2'b00;
`else
    return 2'($urandom);
`endif
  endfunction

  // Run one frame from IDLE; called at a falling edge, returns at a falling edge in IDLE
  // ready_mode: 0 = always ready, 1 = toggle 1/0, 2 = random
  task automatic applyStimulus(input int ready_mode, input bit random_valid, input bit poke_start,
                               input bit start_at_exit);
    int         sent;
    int         got;
    int         cycles;
    int         total;
    bit         prev_stall;
    bit         toggle;
    logic [1:0] prev_tx;
    logic       prev_last;
    sent = 0; got = 0; cycles = 0; prev_stall = 0; toggle = 1;
    prev_tx = '0; prev_last = 0;
    buildExpected();
    total = exp_syms.size();
    obs_syms.delete();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    checkOutput("busy_after_start", busy, 1);
    while (got < total && cycles < 2000) begin
      case (ready_mode)
        0: tx_ready = 1'b1;
        1: begin
          tx_ready = toggle;
          toggle   = !toggle;
        end
        default: tx_ready = ($urandom_range(0, 2) != 0);
      endcase
      if (sent < FL) begin
        din_valid = random_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
        Dx        = 1'(frame_bits[sent]);
      end else begin
        din_valid = 1'($urandom_range(0, 1));
        Dx        = 1'($urandom);
      end
      start    = poke_start && (cycles % 3 == 1);
      err_mask = pickMask();
      #1;
      if (prev_stall) begin
        checkOutput("hold_oe", oe, 1);
        checkOutput("hold_tx", Tx, prev_tx);
        checkOutput("hold_last", tx_last, prev_last);
      end
      if (oe && !tx_ready) checkOutput("din_ready_stall", din_ready, 0);
      if (din_valid && din_ready) begin
        if (sent < FL) sent++;
        else checkOutput("din_ready_tail", din_ready, 0);
      end
      if (oe && tx_ready) begin
        checkOutput("tx_sym", Tx, exp_syms[got]);
        checkOutput("tx_last", tx_last, (got == total - 1));
        obs_syms.push_back(Tx);
        got++;
        if (got == total && start_at_exit) start = 1'b1;
      end
      prev_stall = oe && !tx_ready;
      prev_tx    = Tx;
      prev_last  = tx_last;
      @(negedge clock);
      cycles++;
    end
    if (got < total) checkOutput("frame_timeout", got, total);
    start     = 1'b0;
    din_valid = 1'b0;
    tx_ready  = 1'b1;
    checkOutput("busy_end", busy, 0);
    checkOutput("oe_end", oe, 0);
    checkOutput("state_zero", dut.s_reg, 0);
    @(negedge clock);
    checkOutput("idle_hold", busy, 0);
  endtask

  task automatic checkGolden(input string tag);
    checkOutput({tag, "_count"}, obs_syms.size(), 7);
    for (int i = 0; i < 7 && i < obs_syms.size(); i++) begin
      checkOutput(tag, obs_syms[i], golden[i]);
    end
  endtask

  initial begin
    int sent;
    reset     = 1'b0;
    start     = 1'b0;
    Dx        = '0;
    din_valid = 1'b0;
    tx_ready  = 1'b1;
    err_mask  = '0;
    repeat (2) @(negedge clock);
    checkOutput("rst_oe", oe, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_tx", Tx, 0);
    checkOutput("rst_last", tx_last, 0);
    checkOutput("rst_din_ready", din_ready, 0);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("idle_din_ready", din_ready, 0);

    $display("[TB] frame 1011, ready held high");
    frame_bits = {1, 0, 1, 1};
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    checkGolden("golden_basic");

    $display("[TB] all-zero frame");
    frame_bits = {0, 0, 0, 0};
    applyStimulus(0, 1'b0, 1'b0, 1'b0);

    $display("[TB] frame 1011, ready toggling, start at drain exit");
    frame_bits = {1, 0, 1, 1};
    applyStimulus(1, 1'b0, 1'b0, 1'b1);
    checkGolden("golden_toggle");

    $display("[TB] frame 1011 with stray start pulses");
    frame_bits = {1, 0, 1, 1};
    applyStimulus(0, 1'b0, 1'b1, 1'b0);
    checkGolden("golden_poke");

    $display("[TB] reset after second data bit");
    frame_bits = {1, 0, 1, 1};
    start = 1'b1;
    @(negedge clock);
    start     = 1'b0;
    tx_ready  = 1'b1;
    din_valid = 1'b1;
    sent      = 0;
    for (int c = 0; c < 20 && sent < 2; c++) begin
      Dx = 1'(frame_bits[sent]);
      #1;
      if (din_ready) sent++;
      @(negedge clock);
    end
    din_valid = 1'b0;
    checkOutput("mid_busy", busy, 1);
    checkOutput("mid_oe", oe, 1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_oe", oe, 0);
    checkOutput("async_busy", busy, 0);
    checkOutput("async_tx", Tx, 0);
    checkOutput("async_last", tx_last, 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    checkGolden("golden_after_reset");

    $display("[TB] randomized frames");
    for (int f = 0; f < 25; f++) begin
      frame_bits.delete();
      for (int i = 0; i < FL; i++) frame_bits.push_back(int'($urandom_range(0, 1)));
      applyStimulus(2, 1'b1, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
